// File: rtl/alu_ctrl.sv
// Sequencing front-end for the one-hot alu: accepts binary commands, drives one
// execute cycle, captures result/zero into a response register and an accumulator.
module alu_ctrl #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic          cmd_use_acc,
    input  logic          cmd_wr_acc,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    output logic [6:0]    alu_opcode,
    output logic [DW-1:0] alu_op_0,
    output logic [DW-1:0] alu_op_1,
    input  logic [DW-1:0] alu_result,
    input  logic          alu_zero_f,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [DW-1:0] res_data,
    output logic          res_zero,
    output logic          res_err,
    output logic [DW-1:0] acc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_reg;
    logic          cmd_ready_reg;
    logic          res_valid_reg;
    logic [6:0]    opcode_reg;
    logic [DW-1:0] op_0_reg;
    logic [DW-1:0] op_1_reg;
    logic          wr_acc_reg;
    logic [DW-1:0] res_data_reg;
    logic          res_zero_reg;
    logic          res_err_reg;
    logic [DW-1:0] acc_reg;

    logic [6:0]    onehot;
    logic          illegal;
    logic          accept;

    // Binary-to-one-hot decode; code 7 has no ALU function and decodes to zero.
    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_decode
            assign onehot[gi] = (cmd_op == 3'(gi));
        end
    endgenerate

    assign illegal = (cmd_op == 3'd7);
    assign accept  = cmd_valid & cmd_ready_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            cmd_ready_reg <= 1'b1;
            res_valid_reg <= 1'b0;
            opcode_reg    <= '0;
            op_0_reg      <= '0;
            op_1_reg      <= '0;
            wr_acc_reg    <= 1'b0;
            res_data_reg  <= '0;
            res_zero_reg  <= 1'b0;
            res_err_reg   <= 1'b0;
            acc_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cmd_ready_reg <= 1'b0;
                        if (illegal) begin
                            res_err_reg   <= 1'b1;
                            res_data_reg  <= '0;
                            res_zero_reg  <= 1'b0;
                            res_valid_reg <= 1'b1;
                            state_reg     <= RESP;
                        end else begin
                            // op_0 samples the accumulator before this command can write it.
                            opcode_reg <= onehot;
                            op_0_reg   <= cmd_use_acc ? acc_reg : cmd_a;
                            op_1_reg   <= cmd_b;
                            wr_acc_reg <= cmd_wr_acc;
                            state_reg  <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    res_data_reg  <= alu_result;
                    res_zero_reg  <= alu_zero_f;
                    res_err_reg   <= 1'b0;
                    if (wr_acc_reg) begin
                        acc_reg <= alu_result;
                    end
                    opcode_reg    <= '0;
                    res_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        cmd_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    cmd_ready_reg <= 1'b1;
                    res_valid_reg <= 1'b0;
                    opcode_reg    <= '0;
                end
            endcase
        end
    end

    assign cmd_ready  = cmd_ready_reg;
    assign res_valid  = res_valid_reg;
    assign alu_opcode = opcode_reg;
    assign alu_op_0   = op_0_reg;
    assign alu_op_1   = op_1_reg;
    assign res_data   = res_data_reg;
    assign res_zero   = res_zero_reg;
    assign res_err    = res_err_reg;
    assign acc        = acc_reg;

endmodule
